// File: rtl/pgm_tx.sv
// pgm_tx: replays a 134-bit RAM packet template onto the mux stream, paced by the LCM.
// Optional: define PGM_TIMESTAMP_EN to stamp lcm2pgm_time into head word bits [63:0].
module pgm_tx #(
  parameter logic [47:0] PLATFORM = "Xilinx"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lcm2pgm_reset,
  input  logic         lcm2pgm_start,
  input  logic         lcm2pgm_stop,
  input  logic [10:0]  lcm2pgm_pkt_words,
  input  logic [31:0]  lcm2pgm_pkt_total,
  input  logic [15:0]  lcm2pgm_gap,
  input  logic [63:0]  lcm2pgm_time,
  input  logic         mux2pgm_alf,
  output logic         pgm2ram_rd,
  output logic [10:0]  pgm2ram_rd_addr,
  input  logic [133:0] ram2pgm_data,
  output logic [133:0] pgm2mux_data,
  output logic         pgm2mux_data_wr,
  output logic         pgm2mux_valid,
  output logic         pgm2mux_valid_wr,
  output logic         pgm_busy,
  output logic [63:0]  pgm_pkt_num,
  output logic [63:0]  pgm_byte_num
);

  typedef enum logic [1:0] {StIdle, StWaitAlf, StRead, StGap} state_e;

  state_e       state_q;
  logic         rd_q;
  logic [10:0]  addr_q;
  logic [10:0]  words_q;
  logic [31:0]  total_q;
  logic [31:0]  run_cnt_q;
  logic [15:0]  gap_q;
  logic [15:0]  gap_cnt_q;
  logic         stop_pend_q;
  logic         s2_vld_q;
  logic         s2_head_q;
  logic         s2_tail_q;
  logic [133:0] data_q;
  logic [133:0] word_d;
  logic         data_wr_q;
  logic         valid_wr_q;
  logic [63:0]  pkt_num_q;
  logic [63:0]  byte_num_q;
  logic [63:0]  tail_bytes;
  logic [10:0]  last_addr;
  logic [31:0]  cnt_after;
  logic         stop_seen;
  logic         run_done;

  assign last_addr = words_q - 11'd1;
  // Sent count including the packet whose last read is happening this cycle.
  assign cnt_after = (state_q == StRead) ? run_cnt_q + 32'd1 : run_cnt_q;
  assign stop_seen = stop_pend_q | lcm2pgm_stop;
  assign run_done  = stop_seen | ((total_q != 32'd0) & (cnt_after == total_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_q        <= 1'b0;
      addr_q      <= 11'd0;
      words_q     <= 11'd2;
      total_q     <= 32'd0;
      run_cnt_q   <= 32'd0;
      gap_q       <= 16'd0;
      gap_cnt_q   <= 16'd0;
      stop_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lcm2pgm_start) begin
            state_q     <= StWaitAlf;
            words_q     <= (lcm2pgm_pkt_words < 11'd2) ? 11'd2 : lcm2pgm_pkt_words;
            total_q     <= lcm2pgm_pkt_total;
            gap_q       <= lcm2pgm_gap;
            run_cnt_q   <= 32'd0;
            stop_pend_q <= lcm2pgm_stop;
          end
        end
        StWaitAlf: begin
          if (lcm2pgm_stop) begin
            state_q     <= StIdle;
            stop_pend_q <= 1'b0;
          end else if (!mux2pgm_alf) begin
            state_q <= StRead;
            rd_q    <= 1'b1;
            addr_q  <= 11'd0;
          end
        end
        StRead: begin
          if (lcm2pgm_stop) stop_pend_q <= 1'b1;
          if (addr_q == last_addr) begin
            rd_q      <= 1'b0;
            addr_q    <= 11'd0;
            run_cnt_q <= cnt_after;
            if (gap_q == 16'd0) begin
              state_q     <= run_done ? StIdle : StWaitAlf;
              stop_pend_q <= 1'b0;
            end else begin
              state_q   <= StGap;
              gap_cnt_q <= gap_q;
            end
          end else begin
            addr_q <= addr_q + 11'd1;
          end
        end
        StGap: begin
          if (lcm2pgm_stop) stop_pend_q <= 1'b1;
          if (gap_cnt_q == 16'd1) begin
            state_q     <= run_done ? StIdle : StWaitAlf;
            stop_pend_q <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end

  // Stage 2: RAM data is valid this cycle; carry word position alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_head_q <= 1'b0;
      s2_tail_q <= 1'b0;
    end else begin
      s2_vld_q  <= rd_q;
      s2_head_q <= rd_q & (addr_q == 11'd0);
      s2_tail_q <= rd_q & (addr_q == last_addr);
    end
  end

`ifdef PGM_TIMESTAMP_EN
  logic [63:0] ts_q;
  logic        unused_cfg;
  assign unused_cfg = ^PLATFORM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= 64'd0;
    end else if (state_q == StWaitAlf && !lcm2pgm_stop && !mux2pgm_alf) begin
      ts_q <= lcm2pgm_time;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{PLATFORM, lcm2pgm_time};
`endif

  always_comb begin
    word_d = ram2pgm_data;
    word_d[133:132] = s2_head_q ? 2'b01 : (s2_tail_q ? 2'b10 : 2'b11);
`ifdef PGM_TIMESTAMP_EN
    if (s2_head_q) word_d[63:0] = ts_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      valid_wr_q <= 1'b0;
    end else begin
      data_q     <= s2_vld_q ? word_d : '0;
      data_wr_q  <= s2_vld_q;
      valid_wr_q <= s2_vld_q & s2_tail_q;
    end
  end

  assign tail_bytes = (data_q[131:128] == 4'd0) ? 64'd16 : {60'd0, data_q[131:128]};

  // Counters track words as they leave the block; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_num_q  <= 64'd0;
      byte_num_q <= 64'd0;
    end else if (lcm2pgm_reset) begin
      pkt_num_q  <= 64'd0;
      byte_num_q <= 64'd0;
    end else begin
      if (data_wr_q) byte_num_q <= byte_num_q + (valid_wr_q ? tail_bytes : 64'd16);
      if (valid_wr_q) pkt_num_q <= pkt_num_q + 64'd1;
    end
  end

  assign pgm2ram_rd       = rd_q;
  assign pgm2ram_rd_addr  = addr_q;
  assign pgm2mux_data     = data_q;
  assign pgm2mux_data_wr  = data_wr_q;
  assign pgm2mux_valid    = valid_wr_q;
  assign pgm2mux_valid_wr = valid_wr_q;
  assign pgm_busy         = (state_q != StIdle);
  assign pgm_pkt_num      = pkt_num_q;
  assign pgm_byte_num     = byte_num_q;

endmodule

// File: tb/tb_pgm_tx.sv
// Bench for pgm_tx: a RAM model plus an address-stream scoreboard checked every cycle,
// and directed runs with hand-computed counts, spacing and header values.
module tb_pgm_tx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lcm2pgm_reset = 1'b0;
  logic         lcm2pgm_start = 1'b0;
  logic         lcm2pgm_stop = 1'b0;
  logic [10:0]  lcm2pgm_pkt_words = 11'd4;
  logic [31:0]  lcm2pgm_pkt_total = 32'd0;
  logic [15:0]  lcm2pgm_gap = 16'd0;
  logic [63:0]  lcm2pgm_time = 64'h1234;
  logic         mux2pgm_alf = 1'b0;
  logic         pgm2ram_rd;
  logic [10:0]  pgm2ram_rd_addr;
  logic [133:0] ram2pgm_data;
  logic [133:0] pgm2mux_data;
  logic         pgm2mux_data_wr;
  logic         pgm2mux_valid;
  logic         pgm2mux_valid_wr;
  logic         pgm_busy;
  logic [63:0]  pgm_pkt_num;
  logic [63:0]  pgm_byte_num;

  pgm_tx dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .lcm2pgm_reset     (lcm2pgm_reset),
    .lcm2pgm_start     (lcm2pgm_start),
    .lcm2pgm_stop      (lcm2pgm_stop),
    .lcm2pgm_pkt_words (lcm2pgm_pkt_words),
    .lcm2pgm_pkt_total (lcm2pgm_pkt_total),
    .lcm2pgm_gap       (lcm2pgm_gap),
    .lcm2pgm_time      (lcm2pgm_time),
    .mux2pgm_alf       (mux2pgm_alf),
    .pgm2ram_rd        (pgm2ram_rd),
    .pgm2ram_rd_addr   (pgm2ram_rd_addr),
    .ram2pgm_data      (ram2pgm_data),
    .pgm2mux_data      (pgm2mux_data),
    .pgm2mux_data_wr   (pgm2mux_data_wr),
    .pgm2mux_valid     (pgm2mux_valid),
    .pgm2mux_valid_wr  (pgm2mux_valid_wr),
    .pgm_busy          (pgm_busy),
    .pgm_pkt_num       (pgm_pkt_num),
    .pgm_byte_num      (pgm_byte_num)
  );

  always #5 clk = ~clk;

  logic [133:0] ram [0:2047];
  logic [133:0] ram_q = '0;
  always @(posedge clk) if (pgm2ram_rd) ram_q <= ram[pgm2ram_rd_addr];
  assign ram2pgm_data = ram_q;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard state
  int           cyc = 0;
  logic [10:0]  m_words = 11'd2;
  logic [10:0]  exp_addr = 11'd0;
  logic [63:0]  m_pkt = 64'd0;
  logic [63:0]  m_byte = 64'd0;
  logic [133:0] p1_w = '0, p2_w = '0, nw;
  logic         p1_vld = 1'b0, p2_vld = 1'b0, p1_tail = 1'b0, p2_tail = 1'b0, n_tail;
  int           rd_total = 0;
  int           spacing_last = 0;
  int           last_rd_cyc = 0;
  logic         have_rd = 1'b0;
  logic [63:0]  last_time = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctl", 134'({pgm2ram_rd, pgm2ram_rd_addr, pgm2mux_data_wr, pgm2mux_valid,
                           pgm2mux_valid_wr, pgm_busy}), '0);
      chk("rst_data", pgm2mux_data, '0);
      chk("rst_cnt", 134'({pgm_pkt_num, pgm_byte_num}), '0);
      p1_vld = 1'b0; p2_vld = 1'b0; exp_addr = 11'd0; have_rd = 1'b0;
      m_pkt = 64'd0; m_byte = 64'd0;
    end else begin
      chk("data_wr", 134'(pgm2mux_data_wr), 134'(p2_vld));
      if (p2_vld) begin
        chk("word", pgm2mux_data, p2_w);
        chk("valid_strobes", 134'({pgm2mux_valid_wr, pgm2mux_valid}), 134'({p2_tail, p2_tail}));
      end else begin
        chk("idle_strobes", 134'({pgm2mux_valid_wr, pgm2mux_valid}), '0);
      end
      chk("pkt_num", 134'(pgm_pkt_num), 134'(m_pkt));
      chk("byte_num", 134'(pgm_byte_num), 134'(m_byte));
      if (lcm2pgm_reset) begin
        m_pkt = 64'd0;
        m_byte = 64'd0;
      end else if (p2_vld) begin
        if (p2_tail) begin
          m_pkt = m_pkt + 64'd1;
          m_byte = m_byte + ((p2_w[131:128] == 4'd0) ? 64'd16 : 64'(p2_w[131:128]));
        end else begin
          m_byte = m_byte + 64'd16;
        end
      end
      if (exp_addr != 11'd0) chk("rd_contig", 134'(pgm2ram_rd), 134'(1));
      n_tail = 1'b0;
      nw = '0;
      if (pgm2ram_rd) begin
        chk("rd_addr", 134'(pgm2ram_rd_addr), 134'(exp_addr));
        nw = ram[exp_addr];
        n_tail = (exp_addr == m_words - 11'd1);
        nw[133:132] = (exp_addr == 11'd0) ? 2'b01 : (n_tail ? 2'b10 : 2'b11);
`ifdef PGM_TIMESTAMP_EN
        if (exp_addr == 11'd0) nw[63:0] = last_time;
`endif
        if (exp_addr == 11'd0 && have_rd) spacing_last = cyc - last_rd_cyc;
        have_rd = 1'b1;
        last_rd_cyc = cyc;
        rd_total++;
        exp_addr = n_tail ? 11'd0 : exp_addr + 11'd1;
      end
      p2_vld = p1_vld; p2_w = p1_w; p2_tail = p1_tail;
      p1_vld = pgm2ram_rd; p1_w = nw; p1_tail = n_tail;
    end
    last_time = lcm2pgm_time;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int words, input int total, input int gap);
    lcm2pgm_pkt_words = 11'(words);
    lcm2pgm_pkt_total = 32'(total);
    lcm2pgm_gap = 16'(gap);
    m_words = (words < 2) ? 11'd2 : 11'(words);
    lcm2pgm_start = 1'b1;
    tick;
    lcm2pgm_start = 1'b0;
    chk("busy_after_start", 134'(pgm_busy), 134'(1));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (pgm_busy && n < budget) begin
      tick;
      n++;
    end
    chk("idle_reached", 134'(pgm_busy), 134'(0));
    repeat (3) tick;
  endtask

  task automatic clear_stats;
    lcm2pgm_reset = 1'b1;
    tick;
    lcm2pgm_reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int r0;
    int n;
    logic [7:0] hdrs;
    for (int i = 0; i < 2048; i++)
      ram[i] = {2'b00, 4'h0, 32'hDEAD0000 + 32'(i), 32'h0, 64'h1000 + 64'(i * 7)};
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    chk("reset_busy", 134'(pgm_busy), 134'(0));
    chk("reset_counts", 134'({pgm_pkt_num, pgm_byte_num}), '0);

    // 3 packets of 4 words, gap 5
    r0 = rd_total;
    start_run(4, 3, 5);
    n = 0;
    while (!pgm2mux_data_wr && n < 20) begin
      tick;
      n++;
    end
    hdrs = '0;
    for (int k = 0; k < 4; k++) begin
      hdrs = {hdrs[5:0], pgm2mux_data[133:132]};
      tick;
    end
    chk("t1_headers", 134'(hdrs), 134'(8'b01_11_11_10));
    wait_idle(200);
    chk("t1_pkts", 134'(pgm_pkt_num), 134'(3));
    chk("t1_bytes", 134'(pgm_byte_num), 134'(192));
    chk("t1_spacing", 134'(spacing_last), 134'(7));
    chk("t1_rds", 134'(rd_total - r0), 134'(12));

    // tail with 4 valid bytes: 16+16+4 per packet
    clear_stats;
    ram[2][131:128] = 4'd4;
    start_run(3, 2, 0);
    wait_idle(100);
    chk("t2_pkts", 134'(pgm_pkt_num), 134'(2));
    chk("t2_bytes", 134'(pgm_byte_num), 134'(72));
    chk("t2_spacing", 134'(spacing_last), 134'(2));

    // almost-full holds off the first read; raising it mid-packet does not
    clear_stats;
    mux2pgm_alf = 1'b1;
    r0 = rd_total;
    start_run(3, 1, 2);
    repeat (10) tick;
    chk("t3_no_rd_while_alf", 134'(rd_total - r0), 134'(0));
    mux2pgm_alf = 1'b0;
    tick;
    chk("t3_rd_after_alf", 134'(pgm2ram_rd), 134'(1));
    mux2pgm_alf = 1'b1;
    wait_idle(100);
    mux2pgm_alf = 1'b0;
    chk("t3_rds", 134'(rd_total - r0), 134'(3));
    chk("t3_pkts", 134'(pgm_pkt_num), 134'(1));

    // stop while waiting on almost-full returns to idle at once
    mux2pgm_alf = 1'b1;
    r0 = rd_total;
    start_run(3, 0, 0);
    tick;
    lcm2pgm_stop = 1'b1;
    tick;
    lcm2pgm_stop = 1'b0;
    chk("t3b_stop_idle", 134'(pgm_busy), 134'(0));
    mux2pgm_alf = 1'b0;
    repeat (3) tick;
    chk("t3b_no_rd", 134'(rd_total - r0), 134'(0));

    // continuous run, stop in the middle of the second packet
    clear_stats;
    r0 = rd_total;
    start_run(4, 0, 3);
    n = 0;
    while (rd_total - r0 < 6 && n < 100) begin
      tick;
      n++;
    end
    lcm2pgm_stop = 1'b1;
    tick;
    lcm2pgm_stop = 1'b0;
    wait_idle(100);
    chk("t4_rds", 134'(rd_total - r0), 134'(8));
    chk("t4_pkts", 134'(pgm_pkt_num), 134'(2));

    // head timestamp or RAM word 0
    lcm2pgm_time = 64'h1234;
    start_run(2, 1, 0);
    n = 0;
    while (!(pgm2mux_data_wr && pgm2mux_data[133:132] == 2'b01) && n < 20) begin
      tick;
      n++;
    end
`ifdef PGM_TIMESTAMP_EN
    chk("t5_head_low", 134'(pgm2mux_data[63:0]), 134'(64'h1234));
`else
    chk("t5_head_low", 134'(pgm2mux_data[63:0]), 134'(64'h1000));
`endif
    wait_idle(50);

    // a one-word template is sent as two words
    r0 = rd_total;
    start_run(1, 1, 0);
    wait_idle(50);
    chk("t6_min_words", 134'(rd_total - r0), 134'(2));

    // asynchronous reset in the middle of a packet
    r0 = rd_total;
    start_run(8, 1, 0);
    n = 0;
    while (!(pgm2ram_rd && pgm2ram_rd_addr == 11'd3) && n < 20) begin
      tick;
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_ctl", 134'({pgm2ram_rd, pgm2mux_data_wr, pgm2mux_valid_wr, pgm_busy}), '0);
    chk("t7_async_cnt", 134'({pgm_pkt_num, pgm_byte_num}), '0);
    chk("t7_async_data", pgm2mux_data, '0);
    tick;
    rst_n = 1'b1;
    r0 = rd_total;
    repeat (5) tick;
    chk("t7_stays_idle", 134'(pgm_busy), 134'(0));
    chk("t7_no_rd", 134'(rd_total - r0), 134'(0));

    // statistics clear coincident with the tail write
    start_run(3, 1, 0);
    n = 0;
    while (!pgm2mux_valid_wr && n < 20) begin
      tick;
      n++;
    end
    lcm2pgm_reset = 1'b1;
    tick;
    lcm2pgm_reset = 1'b0;
    chk("t8_pkt_cleared", 134'(pgm_pkt_num), 134'(0));
    chk("t8_byte_cleared", 134'(pgm_byte_num), 134'(0));
    wait_idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
